// File: rtl/merge_engine.sv
`timescale 1ns/1ps
// merge_engine
// Move/merge stage of the 2048 datapath. A direction pulse captures the 4x4
// board of 4-bit cells. The engine then slides and merges one line per clock
// toward the chosen edge. Finally it publishes the new board, a moved flag and
// the score increment.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   up/down/left/right
//              direction request pulses (priority up > down > left > right)
//   board_in   current board, cell p = 4*row+col at bits [4p+3:4p]
//   board_out  result board (registered, held until the next move finishes)
//   moved      result board differs from the captured board
//   score_inc  sum of 2^(merged value) over all merges of the move
//   busy       a move is in progress; direction inputs are ignored
//   done       one-cycle pulse when results are valid and moved = 1
module merge_engine (
   input  logic        clk,
   input  logic        rst,
   input  logic        up,
   input  logic        down,
   input  logic        left,
   input  logic        right,
   input  logic [63:0] board_in,
   output logic [63:0] board_out,
   output logic        moved,
   output logic [19:0] score_inc,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {S_IDLE, S_LINE, S_FIN} state_t;
   typedef enum logic [1:0] {D_UP, D_DOWN, D_LEFT, D_RIGHT} dir_t;

   state_t      state;
   dir_t        dir;
   logic [1:0]  k;
   logic [63:0] work;
   logic [63:0] orig;
   logic [19:0] acc;

   logic [15:0] line_cur;
   logic [15:0] line_new;
   logic [19:0] line_score;
   logic [63:0] work_nxt;

   // Board cell index of position pos (in read order) of line ln.
   // For 2-bit values, ~pos equals 3-pos, giving the reversed read order.
   function automatic logic [3:0] cell_idx(input dir_t d, input logic [1:0] ln,
                                           input logic [1:0] pos);
      logic [1:0] r;
      logic [1:0] c;
      case (d)
         D_LEFT:  begin r = ln;   c = pos;  end
         D_RIGHT: begin r = ln;   c = ~pos; end
         D_UP:    begin r = pos;  c = ln;   end
         default: begin r = ~pos; c = ln;   end
      endcase
      return {r, c};
   endfunction

   // Slide/merge one line given in read order (position 0 in bits [3:0]).
   // Returns {score[19:0], line[15:0]}. Value 15 saturates and never merges.
   function automatic logic [35:0] slide_line(input logic [15:0] ln);
      logic [3:0]  c [5];
      logic [3:0]  m [4];
      logic [19:0] sc;
      logic        skip;
      logic [2:0]  n;
      logic [15:0] res;
      for (int i = 0; i < 5; i++) c[i] = 4'd0;
      for (int i = 0; i < 4; i++) m[i] = 4'd0;
      sc   = '0;
      skip = 1'b0;
      n    = 3'd0;
      res  = '0;
      // Compact nonzero cells to the front, order preserved.
      for (int i = 0; i < 4; i++) begin
         if (ln[4*i +: 4] != 4'd0) begin
            c[n] = ln[4*i +: 4];
            n    = n + 3'd1;
         end
      end
      // Merge adjacent equal pairs front to back. A merged result is skipped
      // over together with its partner, so it cannot merge again. c[4] is
      // always zero, so the last cell never pairs past the end.
      n = 3'd0;
      for (int i = 0; i < 4; i++) begin
         if (skip) begin
            skip = 1'b0;
         end else if (c[i] != 4'd0) begin
            if (c[i] == c[i+1] && c[i] != 4'hF) begin
               m[n[1:0]] = c[i] + 4'd1;
               sc        = sc + (20'd1 << (c[i] + 4'd1));
               skip      = 1'b1;
            end else begin
               m[n[1:0]] = c[i];
            end
            n = n + 3'd1;
         end
      end
      for (int i = 0; i < 4; i++) res[4*i +: 4] = m[i];
      return {sc, res};
   endfunction

   // Gather line k of the working board, process it, scatter it back.
   always_comb begin
      line_cur   = '0;
      line_new   = '0;
      line_score = '0;
      work_nxt   = work;
      for (int i = 0; i < 4; i++)
         line_cur[4*i +: 4] = work[{cell_idx(dir, k, 2'(i)), 2'b00} +: 4];
      {line_score, line_new} = slide_line(line_cur);
      for (int i = 0; i < 4; i++)
         work_nxt[{cell_idx(dir, k, 2'(i)), 2'b00} +: 4] = line_new[4*i +: 4];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         dir       <= D_UP;
         k         <= 2'd0;
         work      <= '0;
         orig      <= '0;
         acc       <= '0;
         board_out <= '0;
         moved     <= 1'b0;
         score_inc <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            // Capture stage: accept a press only when idle.
            S_IDLE: begin
               if (up | down | left | right) begin
                  work  <= board_in;
                  orig  <= board_in;
                  dir   <= up ? D_UP : down ? D_DOWN : left ? D_LEFT : D_RIGHT;
                  acc   <= '0;
                  k     <= 2'd0;
                  busy  <= 1'b1;
                  state <= S_LINE;
               end
            end
            // Line stage: one line per clock, k = 0..3.
            S_LINE: begin
               work <= work_nxt;
               acc  <= acc + line_score;
               k    <= k + 2'd1;
               if (k == 2'd3) state <= S_FIN;
            end
            // Publish stage.
            S_FIN: begin
               board_out <= work;
               score_inc <= acc;
               moved     <= (work != orig);
               done      <= (work != orig);
               busy      <= 1'b0;
               state     <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_merge_engine.sv
`timescale 1ns/1ps
module tb_merge_engine;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
   logic [63:0] board_in = '0;
   logic [63:0] board_out;
   logic        moved;
   logic [19:0] score_inc;
   logic        busy;
   logic        done;

   int n_pass  = 0;
   int n_total = 0;

   // Observations recorded by do_move.
   logic busy_at0, busy_at5, busy_at7;
   int   done_cnt, done_cyc;

   merge_engine dut (
      .clk       (clk),
      .rst       (rst),
      .up        (up),
      .down      (down),
      .left      (left),
      .right     (right),
      .board_in  (board_in),
      .board_out (board_out),
      .moved     (moved),
      .score_inc (score_inc),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   // Drive one press (dirs = {up,down,left,right}) and observe 9 cycles.
   // Cycle c is sampled at the falling edge after rising edge t+c.
   // If inj_c >= 0, a right pulse is sampled at edge t+inj_c.
   task automatic do_move(input logic [3:0] dirs, input logic [63:0] b, input int inj_c);
      @(negedge clk);
      board_in = b;
      {up, down, left, right} = dirs;
      @(posedge clk);
      @(negedge clk);
      {up, down, left, right} = 4'b0000;
      busy_at0 = busy;
      done_cnt = 0;
      done_cyc = -1;
      busy_at5 = 1'bx;
      busy_at7 = 1'bx;
      for (int c = 1; c <= 9; c++) begin
         if (c == inj_c) right = 1'b1;
         @(negedge clk);
         if (c == inj_c) right = 1'b0;
         if (done === 1'b1) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = c;
         end
         if (c == 5) busy_at5 = busy;
         if (c == 7) busy_at7 = busy;
      end
   endtask

   task automatic test_reset();
      #2 rst = 1'b1;
      repeat (2) @(negedge clk);
      n_total++; if (board_out !== 64'd0) $display("FAIL reset_board: got %h expected %h", board_out, 64'd0); else n_pass++;
      n_total++; if (moved !== 1'b0) $display("FAIL reset_moved: got %b expected 0", moved); else n_pass++;
      n_total++; if (score_inc !== 20'd0) $display("FAIL reset_score: got %0d expected 0", score_inc); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
      n_total++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else n_pass++;
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_left();
      do_move(4'b0010, 64'h0000_0000_0000_2211, -1);
      n_total++; if (busy_at0 !== 1'b1) $display("FAIL left_busy_start: got %b expected 1", busy_at0); else n_pass++;
      n_total++; if (busy_at5 !== 1'b0) $display("FAIL left_busy_end: got %b expected 0", busy_at5); else n_pass++;
      n_total++; if (done_cyc != 5) $display("FAIL left_done_cycle: got %0d expected 5", done_cyc); else n_pass++;
      n_total++; if (done_cnt != 1) $display("FAIL left_done_count: got %0d expected 1", done_cnt); else n_pass++;
      n_total++; if (board_out !== 64'h0000_0000_0000_0032) $display("FAIL left_board: got %h expected %h", board_out, 64'h32); else n_pass++;
      n_total++; if (score_inc !== 20'd12) $display("FAIL left_score: got %0d expected 12", score_inc); else n_pass++;
      n_total++; if (moved !== 1'b1) $display("FAIL left_moved: got %b expected 1", moved); else n_pass++;
   endtask

   task automatic test_right();
      do_move(4'b0001, 64'h0000_0000_0000_2211, -1);
      n_total++; if (board_out !== 64'h0000_0000_0000_3200) $display("FAIL right_board: got %h expected %h", board_out, 64'h3200); else n_pass++;
      n_total++; if (score_inc !== 20'd12) $display("FAIL right_score: got %0d expected 12", score_inc); else n_pass++;
      n_total++; if (moved !== 1'b1) $display("FAIL right_moved: got %b expected 1", moved); else n_pass++;
      n_total++; if (done_cnt != 1) $display("FAIL right_done_count: got %0d expected 1", done_cnt); else n_pass++;
   endtask

   task automatic test_column();
      do_move(4'b1000, 64'h0001_0001_0001_0001, -1);
      n_total++; if (board_out !== 64'h0000_0000_0002_0002) $display("FAIL up_board: got %h expected %h", board_out, 64'h0000_0000_0002_0002); else n_pass++;
      n_total++; if (score_inc !== 20'd8) $display("FAIL up_score: got %0d expected 8", score_inc); else n_pass++;
      n_total++; if (done_cyc != 5) $display("FAIL up_done_cycle: got %0d expected 5", done_cyc); else n_pass++;
      do_move(4'b0100, 64'h0001_0001_0001_0001, -1);
      n_total++; if (board_out !== 64'h0002_0002_0000_0000) $display("FAIL down_board: got %h expected %h", board_out, 64'h0002_0002_0000_0000); else n_pass++;
      n_total++; if (score_inc !== 20'd8) $display("FAIL down_score: got %0d expected 8", score_inc); else n_pass++;
      n_total++; if (done_cnt != 1) $display("FAIL down_done_count: got %0d expected 1", done_cnt); else n_pass++;
   endtask

   task automatic test_no_move();
      do_move(4'b0010, 64'h0000_0000_0000_0021, -1);
      n_total++; if (board_out !== 64'h0000_0000_0000_0021) $display("FAIL nomove_board: got %h expected %h", board_out, 64'h21); else n_pass++;
      n_total++; if (moved !== 1'b0) $display("FAIL nomove_moved: got %b expected 0", moved); else n_pass++;
      n_total++; if (score_inc !== 20'd0) $display("FAIL nomove_score: got %0d expected 0", score_inc); else n_pass++;
      n_total++; if (done_cnt != 0) $display("FAIL nomove_done_count: got %0d expected 0", done_cnt); else n_pass++;
      n_total++; if (busy_at5 !== 1'b0) $display("FAIL nomove_busy_end: got %b expected 0", busy_at5); else n_pass++;
      do_move(4'b0010, 64'h0000_0000_0000_00FF, -1);
      n_total++; if (board_out !== 64'h0000_0000_0000_00FF) $display("FAIL sat_board: got %h expected %h", board_out, 64'hFF); else n_pass++;
      n_total++; if (moved !== 1'b0) $display("FAIL sat_moved: got %b expected 0", moved); else n_pass++;
      n_total++; if (score_inc !== 20'd0) $display("FAIL sat_score: got %0d expected 0", score_inc); else n_pass++;
      n_total++; if (done_cnt != 0) $display("FAIL sat_done_count: got %0d expected 0", done_cnt); else n_pass++;
   endtask

   // Up wins over left: up gives 0x12 (score 4), left would give 0x1_0002.
   task automatic test_priority_busy();
      do_move(4'b1010, 64'h0000_0000_0001_0011, 2);
      n_total++; if (board_out !== 64'h0000_0000_0000_0012) $display("FAIL prio_board: got %h expected %h", board_out, 64'h12); else n_pass++;
      n_total++; if (score_inc !== 20'd4) $display("FAIL prio_score: got %0d expected 4", score_inc); else n_pass++;
      n_total++; if (done_cnt != 1) $display("FAIL prio_done_count: got %0d expected 1", done_cnt); else n_pass++;
      n_total++; if (busy_at7 !== 1'b0) $display("FAIL prio_busy_after: got %b expected 0", busy_at7); else n_pass++;
   endtask

   task automatic test_reset_mid_move();
      int dcnt;
      @(negedge clk);
      board_in = 64'h0000_0000_0000_2211;
      left = 1'b1;
      @(posedge clk);
      @(negedge clk);
      left = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      n_total++; if (board_out !== 64'd0) $display("FAIL midrst_board: got %h expected %h", board_out, 64'd0); else n_pass++;
      n_total++; if (score_inc !== 20'd0) $display("FAIL midrst_score: got %0d expected 0", score_inc); else n_pass++;
      n_total++; if (moved !== 1'b0) $display("FAIL midrst_moved: got %b expected 0", moved); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b expected 0", busy); else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      dcnt = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (done === 1'b1) dcnt++;
      end
      n_total++; if (dcnt != 0) $display("FAIL midrst_done_count: got %0d expected 0", dcnt); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL midrst_idle: got %b expected 0", busy); else n_pass++;
      do_move(4'b0010, 64'h0000_0000_0000_2211, -1);
      n_total++; if (board_out !== 64'h0000_0000_0000_0032) $display("FAIL after_rst_board: got %h expected %h", board_out, 64'h32); else n_pass++;
      n_total++; if (done_cnt != 1) $display("FAIL after_rst_done_count: got %0d expected 1", done_cnt); else n_pass++;
      n_total++; if (score_inc !== 20'd12) $display("FAIL after_rst_score: got %0d expected 12", score_inc); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_left();
      test_right();
      test_column();
      test_no_move();
      test_priority_busy();
      test_reset_mid_move();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
